// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one single-ported 16-bit external SRAM between the instruction-fetch
// port and the data-memory port of the pipeline. Every 32-bit access is split
// into a low half (bits [15:0]) and a high half (bits [31:16]). Each half lasts
// WAIT_CYCLES cycles. Data requests win over fetches, a write wins over a read
// when both are raised, and an access in flight is never preempted.
//
// Parameters
//   WAIT_CYCLES  cycles per 16-bit half access (>= 1)
//   ADDR_W       SRAM half-word address width
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr           fetch read request and word-aligned byte address
//   if_rdata/if_ready        fetch read data and not-stalled flag
//   mem_rd_req/mem_wr_req    data read / write requests
//   mem_addr/mem_wdata       data byte address and write data
//   mem_rdata/mem_ready      data read result and not-stalled flag
//   sram_addr                SRAM half-word address
//   sram_dq_out/sram_dq_oe   write data and pad drive enable
//   sram_dq_in               read data from the pad
//   sram_we_n                SRAM write enable, active-low
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              mem_rd_req,
    input  logic              mem_wr_req,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_we_n
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    typedef enum logic [1:0] {G_NONE, G_FETCH, G_DREAD, G_DWRITE} grant_t;

    state_t            state;
    grant_t            grant;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-2:0] addr_hw;    // word index; LSB of sram_addr selects the half
    logic [31:0]       wdata;

    logic              mem_pending;
    grant_t            pick_grant;
    logic [ADDR_W-2:0] pick_addr;

    // Byte-offset and out-of-range address bits carry no information here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+1], if_addr[1:0],
                                mem_addr[31:ADDR_W+1], mem_addr[1:0]};

    assign mem_pending = mem_rd_req | mem_wr_req;

    // Arbitration candidate for the IDLE cycle: write > read > fetch.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        pick_grant = G_NONE;
        pick_addr  = if_addr[ADDR_W:2];
        if (mem_wr_req) begin
            pick_grant = G_DWRITE;
            pick_addr  = mem_addr[ADDR_W:2];
        end else if (mem_rd_req) begin
            pick_grant = G_DREAD;
            pick_addr  = mem_addr[ADDR_W:2];
        end else if (if_req) begin
            pick_grant = G_FETCH;
        end
    end

    // A pending data request freezes the whole pipeline, so it also holds fetch.
    assign mem_ready = (state == IDLE && !mem_pending) ||
                       (state == DONE && (grant == G_DREAD || grant == G_DWRITE));
    assign if_ready  = (state == IDLE && !mem_pending && !if_req) ||
                       (state == DONE && grant == G_FETCH && !mem_pending);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            grant       <= G_NONE;
            cnt         <= '0;
            addr_hw     <= '0;
            wdata       <= '0;
            // NOTE: the read-data registers are reset too, since the ports expose them directly.
            if_rdata    <= '0;
            mem_rdata   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_grant != G_NONE) begin
                        grant      <= pick_grant;
                        addr_hw    <= pick_addr;
                        wdata      <= mem_wdata;
                        cnt        <= CNT_LOAD;
                        state      <= LO;
                        // SRAM pins are registered so they change together with the state.
                        sram_addr  <= {pick_addr, 1'b0};
                        sram_we_n  <= (pick_grant != G_DWRITE);
                        sram_dq_oe <= (pick_grant == G_DWRITE);
                        if (pick_grant == G_DWRITE) begin
                            sram_dq_out <= mem_wdata[15:0];
                        end
                    end
                end
                LO: begin
                    if (cnt == '0) begin
                        if (grant == G_FETCH) begin
                            if_rdata[15:0] <= sram_dq_in;
                        end else if (grant == G_DREAD) begin
                            mem_rdata[15:0] <= sram_dq_in;
                        end
                        cnt       <= CNT_LOAD;
                        state     <= HI;
                        sram_addr <= {addr_hw, 1'b1};
                        if (grant == G_DWRITE) begin
                            sram_dq_out <= wdata[31:16];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HI: begin
                    if (cnt == '0) begin
                        if (grant == G_FETCH) begin
                            if_rdata[31:16] <= sram_dq_in;
                        end else if (grant == G_DREAD) begin
                            mem_rdata[31:16] <= sram_dq_in;
                        end
                        state      <= DONE;
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Grant is kept so the ready terms can name the finished port.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
